// File: rtl/pipelined_segment_adder.sv
// WIDTH-bit adder split into SEG-bit segments, one segment per pipeline stage, with valid/ready at both ends.
// Define PIPELINED_SEGMENT_ADDER_SUB_EN to add the Sub input (A - B) and the signed-overflow output V.
module pipelined_segment_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef PIPELINED_SEGMENT_ADDER_SUB_EN
  input  logic             Sub,
  output logic             V,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Result,
  output logic             C,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NSTG = WIDTH / SEG;

  if ((WIDTH % SEG) != 0) begin : g_width_chk
    $error("pipelined_segment_adder: WIDTH must be an integer multiple of SEG");
  end

  typedef struct packed {
    logic             vld;
    logic             cy;
`ifdef PIPELINED_SEGMENT_ADDER_SUB_EN
    logic             v;
`endif
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stg_t;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                           input logic ci);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  stg_t stg_q [NSTG];
  logic stall;
  logic adv;

  // The whole pipe freezes, bubbles included, while the output is held
  assign stall    = stg_q[NSTG-1].vld & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    stg_t           src;
    stg_t           stg_d;
    logic [SEG:0]   seg;

    if (k == 0) begin : g_src_in
      always_comb begin
        src     = '0;
        src.vld = in_valid;
        src.a   = A;
        src.b   = B;
        src.cy  = Cin;
`ifdef PIPELINED_SEGMENT_ADDER_SUB_EN
        if (Sub) begin
          src.b  = ~B;
          src.cy = 1'b1;
        end
`endif
      end
    end else begin : g_src_fwd
      assign src = stg_q[k-1];
    end

    assign seg = seg_add(src.a[k*SEG +: SEG], src.b[k*SEG +: SEG], src.cy);

    // Data only loads for a valid operand so a bubble leaves the last result on the outputs
    always_comb begin
      stg_d = stg_q[k];
      if (adv) begin
        stg_d.vld = src.vld;
        if (src.vld) begin
          stg_d.a                  = src.a;
          stg_d.b                  = src.b;
          stg_d.sum                = src.sum;
          stg_d.sum[k*SEG +: SEG]  = seg[SEG-1:0];
          stg_d.cy                 = seg[SEG];
`ifdef PIPELINED_SEGMENT_ADDER_SUB_EN
          stg_d.v = (src.a[WIDTH-1] == src.b[WIDTH-1]) && (seg[SEG-1] != src.a[WIDTH-1]);
`endif
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) stg_q[k] <= '0;
      else     stg_q[k] <= stg_d;
    end
  end

  assign out_valid = stg_q[NSTG-1].vld;
  assign Result    = stg_q[NSTG-1].sum;
  assign C         = stg_q[NSTG-1].cy;
`ifdef PIPELINED_SEGMENT_ADDER_SUB_EN
  assign V         = stg_q[NSTG-1].v;
`endif

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Directed bench for pipelined_segment_adder at WIDTH=16, SEG=4 (four stages).
module tb_pipelined_segment_adder;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Result;
  logic        C;
  logic        out_valid;
  logic        out_ready;
`ifdef PIPELINED_SEGMENT_ADDER_SUB_EN
  logic        Sub;
  logic        V;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] va [8];
  logic [15:0] vb [8];
  logic        vc [8];

  pipelined_segment_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef PIPELINED_SEGMENT_ADDER_SUB_EN
    .Sub       (Sub),
    .V         (V),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Result    (Result),
    .C         (C),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [15:0] er, input logic ec);
    A = a; B = b; Cin = ci; in_valid = 1'b1; out_ready = 1'b1;
`ifdef PIPELINED_SEGMENT_ADDER_SUB_EN
    Sub = 1'b0;
`endif
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
      step();
    end
    #1;
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_result"}, {16'b0, Result}, {16'b0, er});
    check({tag, "_carry"}, {31'b0, C}, {31'b0, ec});
    step();
    #1;
    check({tag, "_bubble_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_bubble_hold"}, {15'b0, C, Result}, {15'b0, ec, er});
  endtask

`ifdef PIPELINED_SEGMENT_ADDER_SUB_EN
  task automatic single_sub(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] er, input logic ec, input logic ev);
    A = a; B = b; Cin = 1'b0; Sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    Sub = 1'b0;
    step(); step(); step();
    #1;
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_result"}, {16'b0, Result}, {16'b0, er});
    check({tag, "_carry"}, {31'b0, C}, {31'b0, ec});
    check({tag, "_ovf"}, {31'b0, V}, {31'b0, ev});
    step();
  endtask
`endif

  task automatic run_stream(input string tag, input int n, input int st_start, input int st_len);
    logic [16:0] exp_q [$];
    logic [16:0] held;
    logic [16:0] e;
    bit          was_stall;
    int          sent;
    int          got;
    int          first;
    int          last;
    sent = 0; got = 0; first = -1; last = -1; was_stall = 0; held = '0;
    for (int cyc = 0; cyc < 100 && got < n; cyc++) begin
      if (sent < n) begin
        A = va[sent]; B = vb[sent]; Cin = vc[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(cyc >= st_start && cyc < st_start + st_len);
      #1;
      if (was_stall) check({tag, "_hold"}, {15'b0, C, Result}, {15'b0, held});
      was_stall = 0;
      if (out_valid && !out_ready) begin
        check({tag, "_stall_in_ready"}, {31'b0, in_ready}, 32'd0);
        held = {C, Result};
        was_stall = 1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_output"}, exp_q.size(), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_sum"}, {15'b0, C, Result}, {15'b0, e});
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, A} + {1'b0, B} + {16'b0, Cin});
        sent++;
      end
      step();
    end
    check({tag, "_count"}, got, n);
    check({tag, "_leftover"}, exp_q.size(), 32'd0);
    if (st_len == 0) check({tag, "_contiguous"}, last - first + 1, n);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    va[0] = 16'h1234; vb[0] = 16'h4321; vc[0] = 1'b0;
    va[1] = 16'hFFFF; vb[1] = 16'h0001; vc[1] = 1'b0;
    va[2] = 16'h0FF0; vb[2] = 16'h00F0; vc[2] = 1'b1;
    va[3] = 16'h8000; vb[3] = 16'h8000; vc[3] = 1'b1;
    va[4] = 16'hA5A5; vb[4] = 16'h5A5A; vc[4] = 1'b1;
    va[5] = 16'h7FFF; vb[5] = 16'h7FFF; vc[5] = 1'b0;
    va[6] = 16'h000F; vb[6] = 16'h0001; vc[6] = 1'b0;
    va[7] = 16'hDEAD; vb[7] = 16'hBEEF; vc[7] = 1'b1;

    rst = 1'b1; A = '0; B = '0; Cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef PIPELINED_SEGMENT_ADDER_SUB_EN
    Sub = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result", {16'b0, Result}, 32'd0);
    check("reset_carry", {31'b0, C}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    step();

    single("add_basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
    single("ripple_ones_plus_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    single("ripple_ones_ones_cin", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    single("seg_boundary", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    run_stream("stream", 8, -10, 0);
    run_stream("backpressure", 6, 4, 3);

    // Three adds in flight, then reset
    for (int i = 0; i < 3; i++) begin
      A = va[i]; B = vb[i]; Cin = vc[i]; in_valid = 1'b1; out_ready = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("flush_result", {16'b0, Result}, 32'd0);
    check("flush_carry", {31'b0, C}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("flush_out_valid", {31'b0, out_valid}, 32'd0);
      step();
    end

    single("after_flush", 16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0);

`ifdef PIPELINED_SEGMENT_ADDER_SUB_EN
    single_sub("sub_neg", 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    single_sub("sub_ovf", 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_segment_adder.md
Name: pipelined_segment_adder

Overview:
- Parametrised successor to the team's 4-bit ripple-carry adder.
- Adds two WIDTH-bit operands with a carry-in. The add is split into SEG-bit segments, and each segment is added in its own pipeline stage.
- The carry is registered between stages, so clock rate stays independent of WIDTH.
- Valid/ready handshake at both ends; sits in datapaths that need wide adds at full throughput.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of SEG (elaboration error otherwise).
- SEG, 4, bits added per pipeline stage; the number of stages is NSTG = WIDTH/SEG.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in into bit 0.
- in_valid  input  1  operands are valid this cycle.
- in_ready  output  1  the block can accept operands this cycle.
- Result  output  WIDTH  sum bits.
- C  output  1  carry out of bit WIDTH-1.
- out_valid  output  1  Result and C are valid.
- out_ready  input  1  the downstream block accepts the result.

Behaviour:
- Reset: a synchronous reset on rst=1 clears every stage valid bit and clears carry/partial registers.
  - out_valid=0, Result=0, C=0.
  - in_ready=1 from the first cycle after rst deasserts.
- Transfers:
  - Accept happens when in_valid & in_ready.
  - Output handoff happens when out_valid & out_ready.
- Stage k (k=0..NSTG-1):
  - Adds segment k of A and B plus the registered carry from stage k-1 (Cin for stage 0).
  - Writes segment k of the partial result.
  - Forwards the still-unused upper segments of A and B, the partial result so far, its carry and its valid bit.
- Latency:
  - Operands accepted at edge t appear on the outputs with out_valid=1 after edge t+NSTG-1.
  - Example: WIDTH=16, SEG=4 gives 4 stages, so the result is visible 3 cycles after the accepting edge.
  - Throughput: one add per cycle when not stalled.
- Stall: stall = out_valid & ~out_ready.
  - While stalled, every stage register holds, including bubbles; there is no bubble compression.
  - in_ready = ~stall (combinational).
  - Result and C stay stable while out_valid=1 and out_ready=0.
- Bubbles: in_valid=0 on an accepting cycle inserts a stage with valid=0. A bubble reaching the output stage gives out_valid=0, and Result/C hold their last value.
- Arithmetic:
  - Unsigned modulo 2^WIDTH.
  - {C, Result} = A + B + Cin exactly.
  - Carry propagates across segment boundaries only through the stage carry registers.
- Boundaries:
  - All-ones + 1 (or all-ones + all-ones + 1) must ripple correctly through every stage; the team treats these as carry-chain wrap cases.
  - A simultaneous output handoff and new accept in the same cycle is allowed; the pipe advances.
  - rst asserted mid-operation flushes all in-flight adds. No result from before the reset is ever presented.
- Degenerate case: SEG=WIDTH is legal and gives a single stage with latency 1 edge.

Optional Feature:
- Macro: PIPELINED_SEGMENT_ADDER_SUB_EN.
- Defined:
  - Adds input port Sub (1 bit), sampled with the operands and carried down the pipe.
  - Sub=1 computes A - B as A + ~B + 1 (Cin ignored).
  - C=1 means no borrow.
  - Adds output V (1 bit): signed overflow of the selected operation, valid with out_valid, reset 0.
- Undefined: no Sub and no V ports; the block is add-only as described above.

Test Plan (WIDTH=16, SEG=4):
- Reset then single add: A=16'h1234, B=16'h1111, Cin=0, out_ready=1 -> out_valid after 4 edges, Result=16'h2345, C=0.
- Full carry ripple: A=16'hFFFF, B=16'h0000, Cin=1 -> Result=16'h0000, C=1; A=B=16'hFFFF, Cin=1 -> Result=16'hFFFF, C=1.
- Back-to-back stream: 8 random operand pairs on consecutive cycles, out_ready=1 -> 8 consecutive out_valid cycles, in order, matching a reference model.
- Backpressure: stream 6 adds, drop out_ready for 3 cycles mid-stream -> in_ready=0 while stalled, outputs held stable, no loss or duplication, order preserved.
- Reset mid-flight: accept 3 adds, assert rst on the next cycle -> out_valid=0 for all following cycles until new operands arrive.
- With SUB_EN: A=16'h0005, B=16'h0007, Sub=1 -> Result=16'hFFFE, C=0, V=0; A=16'h8000, B=16'h0001, Sub=1 -> Result=16'h7FFF, V=1.
